// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int MUL_CYCLES_DEF  = 4;
  localparam int DIV_CYCLES_DEF  = 12;
  localparam int MEM_TIMEOUT_DEF = 64;

  // $0 is hardwired, so a write to it is never a real producer.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide occupancy counter: loads on accepted issue, counts down to idle.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  input  logic div,
  output logic busy
);

  localparam logic [3:0] MUL_LD = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_LD = 4'(DIV_CYCLES);

  logic [3:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (start && (cnt == 4'd0))
      cnt_nxt = div ? DIV_LD : MUL_LD;
    else if (cnt != 4'd0)
      cnt_nxt = cnt - 4'd1;
  end

  // busy tracks cnt!=0 exactly but comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt  <= 4'd0;
      busy <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != 4'd0);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the 5-stage MIPS pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES  = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs_d_i,
  input  logic [4:0] rt_d_i,
  input  logic [1:0] branch_d_i,
  input  logic       jr_d_i,
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rt_e_i,
  input  logic [4:0] write_reg_e_i,
  input  logic [4:0] write_reg_m_i,
  input  logic [4:0] write_reg_w_i,
  input  logic       reg_write_e_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  input  logic       mem_to_reg_e_i,
  input  logic       mem_to_reg_m_i,
  input  logic       md_start_e_i,
  input  logic       md_div_e_i,
  input  logic       md_use_e_i,
  input  logic       mem_req_m_i,
  input  logic       mem_ready_i,
  output logic       forward_a_d_o,
  output logic       forward_b_d_o,
  output logic [1:0] forward_a_e_o,
  output logic [1:0] forward_b_e_o,
  output logic       stall_f_o,
  output logic       stall_d_o,
  output logic       stall_e_o,
  output logic       stall_m_o,
  output logic       flush_e_o,
  output logic       flush_m_o,
  output logic       flush_w_o,
  output logic       md_busy_o,
  output logic       mem_err_o
);

  localparam int              TW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_MAX = TW'(MEM_TIMEOUT);

  // Operand index 0 = A (rs), 1 = B (rt).
  logic [1:0][4:0] src_d, src_e;
  fwd_sel_e [1:0]  fwd_e;
  logic     [1:0]  fwd_d;

  assign src_d = {rt_d_i, rs_d_i};
  assign src_e = {rt_e_i, rs_e_i};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    always_comb begin
      fwd_e[g] = FWD_REG;
      if (reg_write_m_i && reg_match(write_reg_m_i, src_e[g]))
        fwd_e[g] = FWD_M;
      else if (reg_write_w_i && reg_match(write_reg_w_i, src_e[g]))
        fwd_e[g] = FWD_W;
    end
    assign fwd_d[g] = reg_write_m_i && reg_match(write_reg_m_i, src_d[g]);
  end

  assign forward_a_e_o = fwd_e[0];
  assign forward_b_e_o = fwd_e[1];
  assign forward_a_d_o = fwd_d[0];
  assign forward_b_d_o = fwd_d[1];

  logic lw_stall, br_stall, is_branch, is_ctl;
  logic rs_hit, rt_hit;

  assign lw_stall = mem_to_reg_e_i &&
                    (reg_match(write_reg_e_i, rs_d_i) || reg_match(write_reg_e_i, rt_d_i));

  assign is_branch = (branch_d_i != 2'b00);
  assign is_ctl    = is_branch || jr_d_i;
  assign rs_hit    = (reg_write_e_i  && reg_match(write_reg_e_i, rs_d_i)) ||
                     (mem_to_reg_m_i && reg_match(write_reg_m_i, rs_d_i));
  assign rt_hit    = (reg_write_e_i  && reg_match(write_reg_e_i, rt_d_i)) ||
                     (mem_to_reg_m_i && reg_match(write_reg_m_i, rt_d_i));
  // jr only reads rs, so its rt field is never a dependency.
  assign br_stall  = is_ctl && (rs_hit || (is_branch && rt_hit));

  mem_state_e    state, state_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          err_nxt, mem_wait;

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    err_nxt   = 1'b0;
    mem_wait  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_m_i && !mem_ready_i) begin
          state_nxt = WAIT;
          tmo_nxt   = TW'(1);
          mem_wait  = 1'b1;
        end
      end
      WAIT: begin
        if (mem_ready_i) begin
          state_nxt = IDLE;
          tmo_nxt   = '0;
        end else begin
          mem_wait = 1'b1;
          if (tmo == TMO_MAX) begin
            state_nxt = IDLE;
            tmo_nxt   = '0;
            err_nxt   = 1'b1;
          end else begin
            tmo_nxt = tmo + TW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      tmo       <= '0;
      mem_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      tmo       <= tmo_nxt;
      mem_err_o <= err_nxt;
    end
  end

  logic md_stall;
  assign md_stall = md_busy_o && md_use_e_i;

  // An issue held in a frozen E stage is re-presented later, so it must not load now.
  md_busy_counter #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .start (md_start_e_i && !stall_e_o),
    .div   (md_div_e_i),
    .busy  (md_busy_o)
  );

  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    flush_e_o = 1'b0;
    flush_m_o = 1'b0;
    flush_w_o = 1'b0;
    if (mem_wait) begin
      {stall_f_o, stall_d_o, stall_e_o, stall_m_o} = 4'b1111;
      flush_w_o = 1'b1;
    end else if (md_stall) begin
      {stall_f_o, stall_d_o, stall_e_o} = 3'b111;
      flush_m_o = 1'b1;
    end else if (lw_stall || br_stall) begin
      {stall_f_o, stall_d_o} = 2'b11;
      flush_e_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: driver queues expectations, monitor checks at negedge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic [1:0] branch_d;
  logic       jr_d, rw_e, rw_m, rw_w, m2r_e, m2r_m;
  logic       md_start, md_div, md_use, mem_req, mem_ready;
  logic       fad, fbd, st_f, st_d, st_e, st_m, fl_e, fl_m, fl_w, busy, err;
  logic [1:0] fae, fbe;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .rs_d_i(rs_d), .rt_d_i(rt_d), .branch_d_i(branch_d), .jr_d_i(jr_d),
    .rs_e_i(rs_e), .rt_e_i(rt_e),
    .write_reg_e_i(wr_e), .write_reg_m_i(wr_m), .write_reg_w_i(wr_w),
    .reg_write_e_i(rw_e), .reg_write_m_i(rw_m), .reg_write_w_i(rw_w),
    .mem_to_reg_e_i(m2r_e), .mem_to_reg_m_i(m2r_m),
    .md_start_e_i(md_start), .md_div_e_i(md_div), .md_use_e_i(md_use),
    .mem_req_m_i(mem_req), .mem_ready_i(mem_ready),
    .forward_a_d_o(fad), .forward_b_d_o(fbd),
    .forward_a_e_o(fae), .forward_b_e_o(fbe),
    .stall_f_o(st_f), .stall_d_o(st_d), .stall_e_o(st_e), .stall_m_o(st_m),
    .flush_e_o(fl_e), .flush_m_o(fl_m), .flush_w_o(fl_w),
    .md_busy_o(busy), .mem_err_o(err)
  );

  typedef struct {
    string       name;
    logic [14:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [14:0] obs;

  // {fwd_d(a,b), fwd_a_e, fwd_b_e, stall f/d/e/m, flush e/m/w, busy, err}
  assign obs = {fad, fbd, fae, fbe, st_f, st_d, st_e, st_m, fl_e, fl_m, fl_w, busy, err};

  localparam logic [3:0] ST_FD  = 4'b1100;
  localparam logic [3:0] ST_FDE = 4'b1110;
  localparam logic [3:0] ST_ALL = 4'b1111;
  localparam logic [2:0] FL_E   = 3'b100;
  localparam logic [2:0] FL_M   = 3'b010;
  localparam logic [2:0] FL_W   = 3'b001;

  function automatic logic [14:0] mk(input logic [1:0] fd, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic [3:0] st,
                                     input logic [2:0] fl, input logic bz, input logic er);
    return {fd, fa, fb, st, fl, bz, er};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        n_chk++;
        if (obs !== cur.exp) begin
          n_fail++;
          $display("FAIL %s got=%b exp=%b (t=%0t)", cur.name, obs, cur.exp, $time);
        end
      end
    end
  end

  task automatic clr();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wr_e = 0; wr_m = 0; wr_w = 0;
    branch_d = 0; jr_d = 0; rw_e = 0; rw_m = 0; rw_w = 0; m2r_e = 0; m2r_m = 0;
    md_start = 0; md_div = 0; md_use = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic cyc(input string nm, input logic [14:0] e);
    exp_t x;
    x.name = nm;
    x.exp  = e;
    sb.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i = 1'b0;
    clr();
    cyc("reset", '0);
    rst_i = 1'b1;
    cyc("idle", '0);

    // forwarding into E and D
    rw_m = 1; wr_m = 8; rw_w = 1; wr_w = 8; rs_e = 8;
    cyc("fwd_e_m_wins", mk(0, 2'b10, 0, 0, 0, 0, 0));
    rw_m = 0;
    cyc("fwd_e_w", mk(0, 2'b01, 0, 0, 0, 0, 0));
    rs_e = 0; rt_e = 8;
    cyc("fwd_e_rt_w", mk(0, 2'b00, 2'b01, 0, 0, 0, 0));
    rw_m = 1; wr_m = 0; wr_w = 0; rt_e = 0;
    cyc("fwd_r0", '0);

    // load-use
    clr(); m2r_e = 1; rw_e = 1; wr_e = 9; rt_d = 9;
    cyc("lw_stall", mk(0, 0, 0, ST_FD, FL_E, 0, 0));
    clr(); m2r_m = 1; rw_m = 1; wr_m = 9; rt_d = 9;
    cyc("lw_bubble", mk(2'b01, 0, 0, 0, 0, 0, 0));
    clr(); rw_w = 1; wr_w = 9; rt_e = 9;
    cyc("lw_fwd_w", mk(0, 0, 2'b01, 0, 0, 0, 0));
    clr(); m2r_e = 1; wr_e = 0;
    cyc("lw_r0", '0);

    // branches and jr
    clr(); branch_d = 2'b01; rs_d = 4; rw_e = 1; wr_e = 4;
    cyc("beq_stall", mk(0, 0, 0, ST_FD, FL_E, 0, 0));
    clr(); branch_d = 2'b01; rs_d = 4; rw_m = 1; wr_m = 4;
    cyc("beq_fwd_d", mk(2'b10, 0, 0, 0, 0, 0, 0));
    clr(); jr_d = 1; rt_d = 5; rw_e = 1; wr_e = 5;
    cyc("jr_rt_ignored", '0);
    clr(); branch_d = 2'b10; rt_d = 6; m2r_m = 1; rw_m = 1; wr_m = 6;
    cyc("bne_load_m", mk(2'b01, 0, 0, ST_FD, FL_E, 0, 0));
    clr(); jr_d = 1; rs_d = 7; rw_e = 1; wr_e = 7;
    cyc("jr_stall", mk(0, 0, 0, ST_FD, FL_E, 0, 0));

    // memory wait with suppressed hazard and ignored md issue
    clr(); mem_req = 1;
    cyc("mw0", mk(0, 0, 0, ST_ALL, FL_W, 0, 0));
    m2r_e = 1; rw_e = 1; wr_e = 9; rt_d = 9;
    cyc("mw1_lw_suppressed", mk(0, 0, 0, ST_ALL, FL_W, 0, 0));
    clr(); mem_req = 1; md_start = 1; md_use = 1;
    cyc("mw2_md_ignored", mk(0, 0, 0, ST_ALL, FL_W, 0, 0));
    clr(); mem_req = 1; mem_ready = 1;
    cyc("mw_release", '0);
    cyc("mw_zero_wait", '0);
    clr();
    cyc("mw_idle", '0);

    // timeout: request cycle plus 64 waiting cycles, then the error pulse
    clr(); mem_req = 1;
    for (int i = 0; i <= 64; i++)
      cyc("tmo_wait", mk(0, 0, 0, ST_ALL, FL_W, 0, 0));
    clr();
    cyc("tmo_err_pulse", mk(0, 0, 0, 0, 0, 0, 1));
    cyc("tmo_err_clear", '0);

    // divide then mfhi
    clr(); md_start = 1; md_div = 1; md_use = 1;
    cyc("div_issue", '0);
    md_start = 0;
    for (int i = 1; i <= 12; i++)
      cyc("mfhi_wait", mk(0, 0, 0, ST_FDE, FL_M, 1, 0));
    cyc("mfhi_go", '0);

    // multiply keeps counting under a memory stall
    clr(); md_start = 1;
    cyc("mul_issue", '0);
    clr(); mem_req = 1;
    for (int i = 1; i <= 4; i++)
      cyc("mul_under_mem", mk(0, 0, 0, ST_ALL, FL_W, 1, 0));
    mem_ready = 1;
    cyc("mul_done", '0);
    clr();
    cyc("mul_idle", '0);

    // async reset mid-WAIT with the divide counter at 7
    clr(); md_start = 1; md_div = 1;
    cyc("div2_issue", '0);
    clr();
    for (int i = 1; i <= 3; i++)
      cyc("div2_count", mk(0, 0, 0, 0, 0, 1, 0));
    mem_req = 1;
    cyc("rst_pre_req", mk(0, 0, 0, ST_ALL, FL_W, 1, 0));
    cyc("rst_pre_wait", mk(0, 0, 0, ST_ALL, FL_W, 1, 0));
    clr(); rst_i = 1'b0;
    cyc("rst_async", '0);
    cyc("rst_hold", '0);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("post_rst_no_err", '0);

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
